// File: rtl/sha_round_ctrl.sv
// Block-level sequencer for an iterative SHA round datapath: loads the chaining
// hash, steps the round index, and folds the final round state into the digest.
module sha_round_ctrl #(
   parameter int BLK_SIZE   = 256,
   parameter int WRD_SIZE   = 32,
   parameter int NUM_ROUNDS = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_start,
   input  logic                i_abort,
   input  logic [BLK_SIZE-1:0] i_pre_blck_hash,
   input  logic [BLK_SIZE-1:0] i_round_hash,
   output logic                o_round_en,
   output logic [BLK_SIZE-1:0] o_round_state,
   output logic [5:0]          o_rc_addr,
   output logic [5:0]          o_w_idx,
   output logic                o_busy,
   output logic                o_done,
   output logic [BLK_SIZE-1:0] o_hash,
   output logic [2:0]          dbg_state
);

   localparam int         NUM_WORDS = BLK_SIZE / WRD_SIZE;
   localparam logic [5:0] LAST_RC   = 6'(NUM_ROUNDS - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      RUN   = 3'd2,
      FINAL = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic   [5:0]          rc;
   logic   [BLK_SIZE-1:0] h_reg;
   logic   [BLK_SIZE-1:0] digest_sum;

   // Handshake: i_start is a level request honoured only in IDLE (abort wins
   // there); o_busy covers LOAD..DONE and o_done pulses once per completed block.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!i_abort && i_start) state_nxt = LOAD;
         LOAD:    state_nxt = i_abort ? IDLE : RUN;
         RUN: begin
            if (i_abort)           state_nxt = IDLE;
            else if (rc == LAST_RC) state_nxt = FINAL;
         end
         FINAL:   state_nxt = i_abort ? IDLE : DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Word-wise modular add; each lane drops its own carry.
   always_comb begin
      digest_sum = '0;
      for (int w = 0; w < NUM_WORDS; w++) begin
         digest_sum[w*WRD_SIZE +: WRD_SIZE] =
            h_reg[w*WRD_SIZE +: WRD_SIZE] + i_round_hash[w*WRD_SIZE +: WRD_SIZE];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         rc     <= '0;
         h_reg  <= '0;
         o_hash <= '0;
      end else begin
         state <= state_nxt;
         if (state == LOAD) h_reg <= i_pre_blck_hash;
         if (state == RUN && rc != LAST_RC) rc <= rc + 6'd1;
         else                               rc <= '0;
         if (state == FINAL && !i_abort) o_hash <= digest_sum;
      end
   end

   always_comb begin
      o_round_en    = (state == RUN);
      o_rc_addr     = (state == RUN) ? rc : 6'd0;
      o_w_idx       = (state == RUN) ? rc : 6'd0;
      o_round_state = (state == RUN && rc == 6'd0) ? h_reg : i_round_hash;
      o_busy        = (state != IDLE);
      o_done        = (state == DONE);
      dbg_state     = state;
   end

endmodule

// File: tb/tb_sha_round_ctrl.sv
// Bench for sha_round_ctrl: drives blocks through a SHA-256 round model and
// scores digests, latency, enable/address timing, abort and reset behaviour.
module tb_sha_round_ctrl;

   localparam logic [255:0] IV     = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [255:0] GOLDEN = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [31:0] K_ROM [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   logic         clk = 1'b0;
   logic         reset;
   logic         i_start;
   logic         i_abort;
   logic [255:0] i_pre_blck_hash;
   logic [255:0] round_hash = '0;
   logic         o_round_en;
   logic [255:0] o_round_state;
   logic [5:0]   o_rc_addr;
   logic [5:0]   o_w_idx;
   logic         o_busy;
   logic         o_done;
   logic [255:0] o_hash;
   logic [2:0]   dbg_state;

   logic [31:0]  w_sched [0:63];
   logic         const_mode = 1'b0;
   logic [255:0] exp_q [$];
   int           checks = 0;
   int           errors = 0;

   sha_round_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .i_start         (i_start),
      .i_abort         (i_abort),
      .i_pre_blck_hash (i_pre_blck_hash),
      .i_round_hash    (round_hash),
      .o_round_en      (o_round_en),
      .o_round_state   (o_round_state),
      .o_rc_addr       (o_rc_addr),
      .o_w_idx         (o_w_idx),
      .o_busy          (o_busy),
      .o_done          (o_done),
      .o_hash          (o_hash),
      .dbg_state       (dbg_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] k, input logic [31:0] w);
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      {a, b, c, d, e, f, g, h} = s;
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      return {t1 + t2, a, b, c, d + t1, e, f, g};
   endfunction

   function automatic logic [255:0] word_add(input logic [255:0] x, input logic [255:0] y);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = x[i*32 +: 32] + y[i*32 +: 32];
      return r;
   endfunction

   // Registered round datapath model fed by the controller's addresses.
   always_ff @(posedge clk) begin
      if (o_round_en)
         round_hash <= const_mode ? {8{32'h00000002}}
                                  : sha_round(o_round_state, K_ROM[o_rc_addr], w_sched[o_w_idx]);
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   // scoreboard: every o_done pops one expected digest
   always @(negedge clk) begin
      if (!reset && o_done) begin
         if (exp_q.size() == 0) check("unexpected_done", 1, 0);
         else check("digest", o_hash, exp_q.pop_front());
      end
   end

   // driver tasks (called right after a negedge)
   task automatic run_block(input logic [255:0] h, input logic cmode, input logic [255:0] exp, input logic hold);
      int en_cnt = 0;
      int exp_rc = 0;
      int lat = 0;
      i_pre_blck_hash = h;
      const_mode = cmode;
      i_start = 1'b1;
      exp_q.push_back(exp);
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         if (k == 1 && !hold) i_start = 1'b0;
         if (o_round_en) begin
            check("rc_addr_seq", o_rc_addr, exp_rc);
            check("w_idx_seq", o_w_idx, exp_rc);
            exp_rc++;
            en_cnt++;
         end
         if (o_done) begin
            lat = k;
            break;
         end
      end
      check("done_latency", lat, 67);
      check("round_en_count", en_cnt, 64);
      check("rc_addr_after_run", o_rc_addr, 0);
      @(negedge clk);
      check("busy_after_done", o_busy, 0);
      if (hold) begin
         @(negedge clk);
         check("b2b_accept_busy", o_busy, 1);
         check("b2b_accept_state", dbg_state, 3'd1);
         i_start = 1'b0;
         i_abort = 1'b1;
         @(negedge clk);
         check("abort_load_busy", o_busy, 0);
         check("abort_load_hash", o_hash, exp);
         i_abort = 1'b0;
      end
   endtask

   task automatic start_only(input logic [255:0] h);
      i_pre_blck_hash = h;
      const_mode = 1'b0;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
   endtask

   task automatic wait_rc(input int target);
      logic found = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (o_round_en && o_rc_addr == 6'(target)) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("rc_reach", found, 1);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_round_en"}, o_round_en, 0);
      check({tag, "_busy"}, o_busy, 0);
      check({tag, "_done"}, o_done, 0);
      check({tag, "_rc_addr"}, o_rc_addr, 0);
      check({tag, "_w_idx"}, o_w_idx, 0);
      check({tag, "_hash"}, o_hash, 0);
   endtask

   initial begin
      logic [255:0] prev;
      w_sched[0] = 32'h61626380;
      for (int t = 1; t < 15; t++) w_sched[t] = 32'h0;
      w_sched[15] = 32'h00000018;
      for (int t = 16; t < 64; t++)
         w_sched[t] = (rotr(w_sched[t-2], 17) ^ rotr(w_sched[t-2], 19) ^ (w_sched[t-2] >> 10))
                    + w_sched[t-7]
                    + (rotr(w_sched[t-15], 7) ^ rotr(w_sched[t-15], 18) ^ (w_sched[t-15] >> 3))
                    + w_sched[t-16];

      // reset with i_start held high: nothing may start
      reset = 1'b1;
      i_start = 1'b1;
      i_abort = 1'b0;
      i_pre_blck_hash = IV;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_outputs_zero("in_reset");
      end
      reset = 1'b0;

      // golden "abc" block, started on the first edge after release
      run_block(IV, 1'b0, GOLDEN, 1'b0);

      // abort wins over start in IDLE
      i_start = 1'b1;
      i_abort = 1'b1;
      @(negedge clk);
      check("idle_abort_wins_busy", o_busy, 0);
      check("idle_abort_wins_state", dbg_state, 3'd0);
      i_start = 1'b0;
      i_abort = 1'b0;
      @(negedge clk);

      // per-word modular add with carries discarded; start held through DONE
      run_block({8{32'hffffffff}}, 1'b1, word_add({8{32'hffffffff}}, {8{32'h00000002}}), 1'b1);
      check("modadd_hash_hold", o_hash, {8{32'h00000001}});

      // abort at rc=30, then restart two cycles later
      prev = o_hash;
      start_only(IV);
      wait_rc(30);
      i_abort = 1'b1;
      @(negedge clk);
      check("abort_round_en", o_round_en, 0);
      check("abort_busy", o_busy, 0);
      check("abort_hash_kept", o_hash, prev);
      i_abort = 1'b0;
      @(negedge clk);
      run_block(IV, 1'b0, GOLDEN, 1'b0);

      // asynchronous reset at rc=10, away from any edge
      start_only(IV);
      wait_rc(10);
      #2 reset = 1'b1;
      #1;
      check_outputs_zero("async_reset");
      check("async_reset_state", dbg_state, 3'd0);
      @(negedge clk);
      check_outputs_zero("reset_held");
      reset = 1'b0;
      run_block(IV, 1'b0, GOLDEN, 1'b0);

      repeat (3) @(negedge clk);
      check("exp_q_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
